aes_uart_sequencer: RTL

//  Byte-level controller between the UART RX/TX byte interfaces and the AES core. Collects an

---
 rtl/aes_uart_sequencer_if.sv | 27 ++
 rtl/aes_uart_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_sequencer_if.sv
// Byte-stream and AES-core signal bundle for aes_uart_sequencer.
// master: the sequencer side; slave: the UART/AES environment side.
interface aes_uart_sequencer_if #(
    parameter int unsigned NBYTES = 16
) ();
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_done;
    logic                  aes_start;
    logic                  aes_ready;
    logic [8*NBYTES-1:0]   pt_to_aes;
    logic [8*NBYTES-1:0]   ct_from_aes;
    logic                  busy;
    logic                  frame_err;

    modport master (
        input  rx_valid, rx_data, tx_done, aes_ready, ct_from_aes,
        output tx_start, tx_data, aes_start, pt_to_aes, busy, frame_err
    );

    modport slave (
        output rx_valid, rx_data, tx_done, aes_ready, ct_from_aes,
        input  tx_start, tx_data, aes_start, pt_to_aes, busy, frame_err
    );
endinterface

// File: rtl/aes_uart_sequencer.sv
// Byte-level sequencer between the UART RX/TX byte ports and the AES core.
// Collects an NBYTES plaintext frame, pulses aes_start, waits for a rising aes_ready,
// then streams the ciphertext out MSB byte first with a tx_start/tx_done handshake.
// Optional feature: define AES_TRIGGER_EN to add the trigger_o scope-trigger output.
module aes_uart_sequencer #(
    parameter int unsigned NBYTES      = 16,
    parameter int unsigned GAP_TIMEOUT = 200000,
    parameter int unsigned AES_TIMEOUT = 4096
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
`ifdef AES_TRIGGER_EN
    output logic                 trigger_o,
`endif
    aes_uart_sequencer_if.master bus
);
    localparam int unsigned BlkW = 8 * NBYTES;
    localparam int unsigned CntW = $clog2(NBYTES + 1);
    localparam int unsigned GapW = $clog2(GAP_TIMEOUT + 1);
    localparam int unsigned AesW = $clog2(AES_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StStart,
        StWaitAes,
        StSend,
        StWaitTx
    } state_e;

    state_e          state_q, state_d;
    logic [BlkW-1:0] pt_q, pt_d;
    logic [BlkW-1:0] ct_q, ct_d;
    logic [BlkW-1:0] ct_shl;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CntW-1:0] idx_q, idx_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [AesW-1:0] aes_cnt_q, aes_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            aes_start_q, aes_start_d;
    logic            frame_err_q, frame_err_d;
    logic            rdy_q;
    logic            rdy_rise;
    logic            aes_expire;

    // Only a 0->1 transition seen while waiting counts as completion.
    assign rdy_rise   = bus.aes_ready & ~rdy_q;
    assign aes_expire = (aes_cnt_q == AesW'(AES_TIMEOUT - 1));
    // Current ciphertext byte lands in the top byte lane.
    assign ct_shl     = ct_q << {idx_q, 3'b000};

    // Next-state and registered-output logic of the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        byte_cnt_d  = byte_cnt_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        aes_cnt_d   = aes_cnt_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        aes_start_d = 1'b0;
        frame_err_d = 1'b0;

        // A byte arriving while a block is being processed is dropped.
        if (bus.rx_valid && (state_q inside {StStart, StWaitAes, StSend, StWaitTx})) begin
            frame_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    pt_d       = (pt_q << 8) | BlkW'(bus.rx_data);
                    byte_cnt_d = CntW'(1);
                    gap_cnt_d  = '0;
                    state_d    = (NBYTES == 1) ? StStart : StRecv;
                end
            end
            StRecv: begin
                // A byte in the timeout cycle wins over the gap abort.
                if (bus.rx_valid) begin
                    pt_d       = (pt_q << 8) | BlkW'(bus.rx_data);
                    byte_cnt_d = byte_cnt_q + CntW'(1);
                    gap_cnt_d  = '0;
                    if (byte_cnt_q + CntW'(1) == CntW'(NBYTES)) begin
                        state_d = StStart;
                    end
                end else if (gap_cnt_q == GapW'(GAP_TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    byte_cnt_d  = '0;
                    state_d     = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            StStart: begin
                aes_start_d = 1'b1;
                aes_cnt_d   = '0;
                state_d     = StWaitAes;
            end
            StWaitAes: begin
                // Completion wins over a coincident timeout.
                if (rdy_rise) begin
                    ct_d    = bus.ct_from_aes;
                    idx_d   = '0;
                    state_d = StSend;
                end else if (aes_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    aes_cnt_d = aes_cnt_q + AesW'(1);
                end
            end
            StSend: begin
                tx_data_d  = ct_shl[BlkW-1 -: 8];
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (bus.tx_done) begin
                    idx_d   = idx_q + CntW'(1);
                    state_d = (idx_q + CntW'(1) == CntW'(NBYTES)) ? StIdle : StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            pt_q        <= '0;
            ct_q        <= '0;
            byte_cnt_q  <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            aes_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            aes_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            byte_cnt_q  <= byte_cnt_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            aes_cnt_q   <= aes_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            aes_start_q <= aes_start_d;
            frame_err_q <= frame_err_d;
            rdy_q       <= bus.aes_ready;
        end
    end

`ifdef AES_TRIGGER_EN
    logic trigger_q;

    // Scope window: opens with aes_start, closes after AES completion or timeout.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            trigger_q <= 1'b0;
        end else if (state_q == StStart) begin
            trigger_q <= 1'b1;
        end else if (state_q == StWaitAes && (rdy_rise || aes_expire)) begin
            trigger_q <= 1'b0;
        end
    end

    assign trigger_o = trigger_q;
`endif

    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.aes_start = aes_start_q;
    assign bus.pt_to_aes = pt_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
